// File: rtl/tx_axis_arbiter.sv
// rtl/tx_axis_arbiter.sv - packet-granular two-source round-robin AXIS arbiter with frame truncation
module tx_axis_arbiter #(
    parameter int MAX_BEATS = 190,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_txc,
    input  logic                 i_tx_reset,
    input  logic [63:0]          s00_axis_tdata,
    input  logic [7:0]           s00_axis_tkeep,
    input  logic                 s00_axis_tvalid,
    input  logic                 s00_axis_tlast,
    output logic                 s00_axis_tready,
    input  logic [63:0]          s01_axis_tdata,
    input  logic [7:0]           s01_axis_tkeep,
    input  logic                 s01_axis_tvalid,
    input  logic                 s01_axis_tlast,
    output logic                 s01_axis_tready,
    output logic [63:0]          m00_axis_tdata,
    output logic [7:0]           m00_axis_tkeep,
    output logic                 m00_axis_tvalid,
    output logic                 m00_axis_tlast,
    input  logic                 m00_axis_tready,
    output logic [1:0]           o_grant,
    output logic [CNT_WIDTH-1:0] o_trunc_count
);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    localparam logic [15:0] LIMIT = 16'(MAX_BEATS - 1);

    state_t               state;
    state_t               state_nxt;
    logic                 sel;
    logic                 sel_nxt;
    logic                 last_grant;
    logic [15:0]          beat_cnt;
    logic [CNT_WIDTH-1:0] trunc_count;

    logic [63:0]          src_data;
    logic [7:0]           src_keep;
    logic                 src_valid;
    logic                 src_last;
    logic                 at_limit;
    logic                 accept;
    logic                 trunc_hit;

    // Source mux driven by the registered owner
    always_comb begin
        src_data  = sel ? s01_axis_tdata  : s00_axis_tdata;
        src_keep  = sel ? s01_axis_tkeep  : s00_axis_tkeep;
        src_valid = sel ? s01_axis_tvalid : s00_axis_tvalid;
        src_last  = sel ? s01_axis_tlast  : s00_axis_tlast;
    end

    assign at_limit      = (beat_cnt == LIMIT);
    assign o_trunc_count = trunc_count;

    // Next-state, owner selection and port outputs; everything is held quiet while reset is asserted
    always_comb begin
        state_nxt       = state;
        sel_nxt         = sel;
        accept          = 1'b0;
        trunc_hit       = 1'b0;
        s00_axis_tready = 1'b0;
        s01_axis_tready = 1'b0;
        m00_axis_tdata  = 64'd0;
        m00_axis_tkeep  = 8'd0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        o_grant         = 2'b00;
        unique case (state)
            IDLE: begin
                if (s00_axis_tvalid && s01_axis_tvalid) begin
                    sel_nxt   = ~last_grant;
                    state_nxt = PASS;
                end else if (s00_axis_tvalid) begin
                    sel_nxt   = 1'b0;
                    state_nxt = PASS;
                end else if (s01_axis_tvalid) begin
                    sel_nxt   = 1'b1;
                    state_nxt = PASS;
                end
            end
            PASS: begin
                m00_axis_tdata  = src_data;
                m00_axis_tkeep  = src_keep;
                m00_axis_tvalid = src_valid;
                // The watchdog beat closes the frame at the MAC even if the source has more
                m00_axis_tlast  = src_last | at_limit;
                s00_axis_tready = ~sel & m00_axis_tready;
                s01_axis_tready = sel & m00_axis_tready;
                o_grant         = {sel, ~sel};
                accept          = src_valid & m00_axis_tready;
                if (accept) begin
                    if (src_last) begin
                        state_nxt = IDLE;
                    end else if (at_limit) begin
                        trunc_hit = 1'b1;
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                s00_axis_tready = ~sel;
                s01_axis_tready = sel;
                o_grant         = {sel, ~sel};
                if (src_valid && src_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (i_tx_reset) begin
            s00_axis_tready = 1'b0;
            s01_axis_tready = 1'b0;
            m00_axis_tvalid = 1'b0;
            m00_axis_tlast  = 1'b0;
            m00_axis_tdata  = 64'd0;
            m00_axis_tkeep  = 8'd0;
            o_grant         = 2'b00;
        end
    end

    // State register
    always_ff @(posedge i_txc) begin
        if (i_tx_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Owner, fairness history, beat watchdog and saturating truncation counter
    always_ff @(posedge i_txc) begin
        if (i_tx_reset) begin
            sel         <= 1'b0;
            last_grant  <= 1'b1;
            beat_cnt    <= 16'd0;
            trunc_count <= '0;
        end else begin
            sel <= sel_nxt;
            if (state == IDLE) begin
                beat_cnt <= 16'd0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
            if (accept && (src_last || at_limit)) begin
                last_grant <= sel;
            end
            if (trunc_hit && (trunc_count != {CNT_WIDTH{1'b1}})) begin
                trunc_count <= trunc_count + 1'b1;
            end
        end
    end

endmodule
